rv32i_lsu: RTL

Load/store unit for the memory stage of the RV32I core. It sits directly downstream of decode/execute: it consumes the ALU-computed effective address, the store data, and the decoded mem_op_e, reg_mask_e and ram_mask_e controls. It drives a word-addressed RAM port with byte enables, then aligns, masks and sign/zero-extends load data for write-back (WB_MEM). It detects misaligned accesses and bus timeouts instead of issuing them silently.

---
 rtl/rv32i_lsu_pkg.sv | 73 +++++++
 rtl/rv32i_lsu_align.sv | 21 ++
 rtl/rv32i_lsu.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rv32i_lsu_pkg.sv
// Shared RV32I memory-stage types plus the lane/extension helpers used by the LSU.
package rv32i_lsu_pkg;

   typedef enum logic {
      MEM_LOAD  = 1'b0,
      MEM_STORE = 1'b1
   } mem_op_e;

   typedef enum logic [2:0] {
      REG_MASK_B  = 3'd0,
      REG_MASK_BX = 3'd1,
      REG_MASK_H  = 3'd2,
      REG_MASK_HX = 3'd3,
      REG_MASK_W  = 3'd4
   } reg_mask_e;

   typedef enum logic [1:0] {
      RAM_MASK_B = 2'd0,
      RAM_MASK_H = 2'd1,
      RAM_MASK_W = 2'd2
   } ram_mask_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   // Unused encodings fall through to the full-word lane set.
   function automatic logic [3:0] lane_be(ram_mask_e m, logic [1:0] off);
      case (m)
         RAM_MASK_B: lane_be = 4'b0001 << off;
         RAM_MASK_H: lane_be = 4'b0011 << off;
         default:    lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_replicate(ram_mask_e m, logic [31:0] d);
      case (m)
         RAM_MASK_B: store_replicate = {4{d[7:0]}};
         RAM_MASK_H: store_replicate = {2{d[15:0]}};
         default:    store_replicate = d;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(reg_mask_e m, logic [31:0] word, logic [1:0] off);
      logic [31:0] s;
      s = word >> {off, 3'b000};
      case (m)
         REG_MASK_B:  load_extend = {{24{s[7]}}, s[7:0]};
         REG_MASK_BX: load_extend = {24'h0, s[7:0]};
         REG_MASK_H:  load_extend = {{16{s[15]}}, s[15:0]};
         REG_MASK_HX: load_extend = {16'h0, s[15:0]};
         default:     load_extend = s;
      endcase
   endfunction

   // Width comes from reg_mask on loads and ram_mask on stores.
   function automatic logic is_misaligned(mem_op_e op, reg_mask_e rm, ram_mask_e wm,
                                          logic [1:0] off);
      logic is_byte;
      logic is_half;
      if (op == MEM_STORE) begin
         is_byte = (wm == RAM_MASK_B);
         is_half = (wm == RAM_MASK_H);
      end else begin
         is_byte = (rm == REG_MASK_B) || (rm == REG_MASK_BX);
         is_half = (rm == REG_MASK_H) || (rm == REG_MASK_HX);
      end
      is_misaligned = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
   endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational lane steering: store replication/byte enables and load shift/extend.
module rv32i_lsu_align
   import rv32i_lsu_pkg::*;
(
   input  ram_mask_e   ram_mask,
   input  reg_mask_e   reg_mask,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] store_wdata,
   output logic [3:0]  store_be,
   output logic [31:0] load_data
);

   always_comb begin
      store_wdata = store_replicate(ram_mask, wdata);
      store_be    = lane_be(ram_mask, off);
      load_data   = load_extend(reg_mask, rdata, off);
   end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: word-addressed RAM port with byte enables, misalign and ack-timeout checks.
module rv32i_lsu
   import rv32i_lsu_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned ADDR_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  mem_op_e               req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  reg_mask_e             req_reg_mask,
   input  ram_mask_e             req_ram_mask,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_misaligned,
   output logic                  resp_bus_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata
);

   localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

   lsu_state_e            state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   mem_op_e               op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   reg_mask_e             reg_mask_q;
   ram_mask_e             ram_mask_q;
   logic [31:0]           rdata_q, rdata_d;
   logic                  mis_q, mis_d;
   logic                  berr_q, berr_d;
   logic                  capture;

   logic [31:0] store_wdata;
   logic [3:0]  store_be;
   logic [31:0] load_data;

   rv32i_lsu_align u_align (
      .ram_mask    (ram_mask_q),
      .reg_mask    (reg_mask_q),
      .off         (addr_q[1:0]),
      .wdata       (wdata_q),
      .rdata       (mem_rdata),
      .store_wdata (store_wdata),
      .store_be    (store_be),
      .load_data   (load_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      mis_d   = mis_q;
      berr_d  = berr_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               capture = 1'b1;
               cnt_d   = '0;
               rdata_d = '0;
               berr_d  = 1'b0;
               if (is_misaligned(req_op, req_reg_mask, req_ram_mask, req_addr[1:0])) begin
                  mis_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  mis_d   = 1'b0;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // An ack in the expiry cycle still completes the access normally.
            if (mem_ack) begin
               rdata_d = (op_q == MEM_LOAD) ? load_data : 32'h0;
               state_d = RESP;
            end else if ((ACK_TIMEOUT != 0) && (cnt_q == CntMax)) begin
               rdata_d = '0;
               berr_d  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q       <= MEM_LOAD;
         addr_q     <= '0;
         wdata_q    <= '0;
         reg_mask_q <= REG_MASK_W;
         ram_mask_q <= RAM_MASK_W;
      end else if (capture) begin
         op_q       <= req_op;
         addr_q     <= req_addr;
         wdata_q    <= req_wdata;
         reg_mask_q <= req_reg_mask;
         ram_mask_q <= req_ram_mask;
      end
   end

   // Memory-side outputs derive only from state and captured fields, so they hold until ack.
   always_comb begin
      req_ready       = (state_q == IDLE);
      mem_req         = (state_q == ACCESS);
      mem_we          = mem_req && (op_q == MEM_STORE);
      mem_addr        = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
      mem_wdata       = mem_we ? store_wdata : 32'h0;
      mem_be          = mem_we ? store_be : 4'b0000;
      resp_valid      = (state_q == RESP);
      resp_rdata      = resp_valid ? rdata_q : 32'h0;
      resp_misaligned = resp_valid && mis_q;
      resp_bus_err    = resp_valid && berr_q;
   end

endmodule
